fifo_wr_arbiter: RTL and testbench

- Round-robin write arbiter that shares one synchronous FIFO (depth 8, 25-bit entries) between NUM_REQ producers, such as PE output lanes.
- Uses valid/ready handshakes on the producer side and a registered write port toward the FIFO.
- Keeps its own occupancy credit count, so no write is ever issued into a full FIFO.
- Sits between the PE array outputs and the accumulation-buffer FIFO.

---
 rtl/fifo_wr_arbiter_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 63 ++++++
 rtl/fifo_wr_arbiter.sv | 135 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter_pkg
//   Shared sizing constants for the FIFO write arbiter and its arbitration
//   core. These are the single source of truth for producer count, grant
//   index width, FIFO entry width, FIFO depth and occupancy-counter width.
//   The top level and the benches both import this package.
//   Optional build macro (used by the files importing this package):
//     FIFO_WR_ARB_FIXED_PRIO_EN - fixed lowest-index-wins priority instead
//                                 of round-robin.
package fifo_wr_arbiter_pkg;

  localparam int ARB_NUM_REQ    = 4;   // number of producers
  localparam int ARB_ID_WIDTH   = 2;   // clog2(ARB_NUM_REQ)
  localparam int ARB_DATA_WIDTH = 25;  // FIFO entry width
  localparam int ARB_DEPTH      = 8;   // downstream FIFO capacity
  localparam int ARB_CNT_WIDTH  = 4;   // clog2(ARB_DEPTH+1)

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Purely combinational arbitration core. Picks one winner from a request
//   vector and reports it both one-hot and as an index.
//   Default build: round-robin; the search starts at i_ptr+1 and wraps
//   modulo NUM_REQ, so the last winner has lowest priority next time.
//   With FIFO_WR_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index
//   wins, and i_ptr is ignored.
// Ports:
//   i_req   [NUM_REQ]   request vector
//   i_ptr   [ID_WIDTH]  index of the previous winner
//   o_grant [NUM_REQ]   one-hot grant (all zero when no request)
//   o_idx   [ID_WIDTH]  index of the granted request
//   o_valid             at least one request is present
module rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic [ID_WIDTH-1:0] i_ptr,
  output logic [NUM_REQ-1:0]  o_grant,
  output logic [ID_WIDTH-1:0] o_idx,
  output logic                o_valid
);

  int w_cand;

`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^i_ptr;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = k;
      if (!o_valid && i_req[w_cand]) begin
        o_valid         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = ID_WIDTH'(w_cand);
      end
    end
  end
`else
  // Offsets 1..NUM_REQ visit every index once, ending on i_ptr itself.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = (int'(i_ptr) + k) % NUM_REQ;
      if (!o_valid && i_req[w_cand]) begin
        o_valid         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = ID_WIDTH'(w_cand);
      end
    end
  end
`endif

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Shares one synchronous FIFO between NUM_REQ producers. Producers use
//   valid/ready; the winner's data is registered onto the FIFO write port
//   one cycle after acceptance. A private occupancy count (credit) makes
//   sure a write is never issued into a full FIFO.
//   Optional build macro: FIFO_WR_ARB_FIXED_PRIO_EN selects fixed
//   lowest-index priority and removes the round-robin pointer.
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   req_valid      per-producer valid
//   req_data       packed producer data, producer i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready      per-producer ready (combinational, at most one bit set)
//   fifo_wr_en     registered FIFO write strobe
//   fifo_data_in   registered FIFO write data
//   fifo_full      FIFO full flag (only used for the overflow check)
//   fifo_rd_en     consumer read strobe into the FIFO
//   fifo_empty     FIFO empty flag
//   grant_id       index of the last accepted producer
//   occupancy      number of reserved FIFO entries
//   ovf_err        sticky: a write was issued while fifo_full was high
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = ARB_NUM_REQ,
  parameter int ID_WIDTH   = ARB_ID_WIDTH,
  parameter int DATA_WIDTH = ARB_DATA_WIDTH,
  parameter int DEPTH      = ARB_DEPTH,
  parameter int CNT_WIDTH  = ARB_CNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  input  logic                          fifo_rd_en,
  input  logic                          fifo_empty,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic [CNT_WIDTH-1:0]          occupancy,
  output logic                          ovf_err
);

  logic                  r_wr_en;
  logic [DATA_WIDTH-1:0] r_data;
  logic [ID_WIDTH-1:0]   r_grant_id;
  logic [CNT_WIDTH-1:0]  r_occupancy;
  logic                  r_ovf_err;

  logic [NUM_REQ-1:0]    w_grant;
  logic [ID_WIDTH-1:0]   w_idx;
  logic                  w_any_valid;
  logic [ID_WIDTH-1:0]   w_ptr;
  logic                  w_credit_ok;
  logic                  w_accept;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_win_data;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (w_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_any_valid)
  );

`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  // Reset to the last index so producer 0 is searched first.
  logic [ID_WIDTH-1:0] r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= ID_WIDTH'(NUM_REQ - 1);
    end else if (w_accept) begin
      r_ptr <= w_idx;
    end
  end

  assign w_ptr = r_ptr;
`endif

  // Conservative credit: a pop in the same cycle does not free a slot early.
  assign w_credit_ok = (r_occupancy < CNT_WIDTH'(DEPTH));
  assign req_ready   = rst ? '0 : (w_grant & {NUM_REQ{w_credit_ok}});
  assign w_accept    = w_any_valid & w_credit_ok & ~rst;
  assign w_pop       = fifo_rd_en & ~fifo_empty;
  assign w_win_data  = req_data[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en    <= 1'b0;
      r_data     <= '0;
      r_grant_id <= '0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_data     <= w_win_data;
        r_grant_id <= w_idx;
      end
    end
  end

  // Accept and pop together leave the count unchanged; both guards keep it
  // inside [0, DEPTH] regardless of inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occupancy <= '0;
    end else if (w_accept && !w_pop && (r_occupancy < CNT_WIDTH'(DEPTH))) begin
      r_occupancy <= r_occupancy + 1'b1;
    end else if (w_pop && !w_accept && (r_occupancy != '0)) begin
      r_occupancy <= r_occupancy - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf_err <= 1'b0;
    end else if (r_wr_en && fifo_full) begin
      r_ovf_err <= 1'b1;
    end
  end

  assign fifo_wr_en   = r_wr_en;
  assign fifo_data_in = r_data;
  assign grant_id     = r_grant_id;
  assign occupancy    = r_occupancy;
  assign ovf_err      = r_ovf_err;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Directed bench for fifo_wr_arbiter. Each accepted request pushes its
//   expected FIFO write (data, producer id) into a queue; a monitor on the
//   falling edge pops and compares whenever fifo_wr_en is high. Occupancy,
//   ready, reset and overflow behaviour are checked directly in the
//   stimulus thread against hand-computed values.
//   Honours FIFO_WR_ARB_FIXED_PRIO_EN for the final priority test.
module tb_fifo_wr_arbiter;
  import fifo_wr_arbiter_pkg::*;

  localparam int NR = ARB_NUM_REQ;
  localparam int DW = ARB_DATA_WIDTH;
  localparam int IW = ARB_ID_WIDTH;
  localparam int CW = ARB_CNT_WIDTH;

  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
  } wr_t;

  logic               clk;
  logic               rst;
  logic [NR-1:0]      req_valid;
  logic [NR*DW-1:0]   req_data;
  logic [NR-1:0]      req_ready;
  logic               fifo_wr_en;
  logic [DW-1:0]      fifo_data_in;
  logic               fifo_full;
  logic               fifo_rd_en;
  logic               fifo_empty;
  logic [IW-1:0]      grant_id;
  logic [CW-1:0]      occupancy;
  logic               ovf_err;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  fifo_wr_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .fifo_full    (fifo_full),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_empty   (fifo_empty),
    .grant_id     (grant_id),
    .occupancy    (occupancy),
    .ovf_err      (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) begin
      n_pass++;
      $display("ok   %s : got %0h", name, act);
    end else begin
      $display("FAIL %s : got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expect_wr(input logic [DW-1:0] d, input logic [IW-1:0] id);
    wr_t w;
    w.data = d;
    w.id   = id;
    exp_q.push_back(w);
  endtask

  task automatic set_data(input int idx, input logic [DW-1:0] d);
    req_data[idx*DW +: DW] = d;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (fifo_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write : got data %0h id %0h, expected no write", fifo_data_in, grant_id);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_data", 32'(fifo_data_in), 32'(w.data));
        check("wr_id", 32'(grant_id), 32'(w.id));
      end
    end
  end

  initial begin
    rst        = 1'b1;
    req_valid  = '1;
    req_data   = '0;
    fifo_full  = 1'b0;
    fifo_rd_en = 1'b0;
    fifo_empty = 1'b1;

    // Reset state; ready forced low even with all producers valid.
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 0);
    check("rst_wr_en", 32'(fifo_wr_en), 0);
    check("rst_data", 32'(fifo_data_in), 0);
    check("rst_grant", 32'(grant_id), 0);
    check("rst_occ", 32'(occupancy), 0);
    check("rst_ovf", 32'(ovf_err), 0);
    req_valid = '0;
    rst       = 1'b0;

    // Single requester: immediate ready, write next cycle.
    set_data(0, 25'd1);
    req_valid = 4'b0001;
    #1 check("single_ready", 32'(req_ready), 32'b0001);
    expect_wr(25'd1, 2'd0);
    tick();
    req_valid = '0;
    check("single_occ", 32'(occupancy), 1);

    // Two more accepts to reach occupancy 3 with a pending write.
    set_data(1, 25'h11);
    req_valid = 4'b0010;
    #1 check("p1_ready", 32'(req_ready), 32'b0010);
    expect_wr(25'h11, 2'd1);
    tick();
    set_data(2, 25'h22);
    req_valid = 4'b0100;
    #1 check("p2_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b0001;
    check("pend_occ", 32'(occupancy), 3);
    check("pend_wr_en", 32'(fifo_wr_en), 1);
    // Mid-cycle reset drops the pending write without a clock edge.
    rst = 1'b1;
    #1;
    check("arst_wr_en", 32'(fifo_wr_en), 0);
    check("arst_occ", 32'(occupancy), 0);
    check("arst_ready", 32'(req_ready), 0);
    tick();
    tick();
    rst = 1'b0;

    // Fairness from reset: all valid, grants rotate 0,1,2,3.
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) set_data(k, 25'(10 * (k + 1)));
    for (int k = 0; k < 4; k++) begin
      #1 check($sformatf("rr_ready_%0d", k), 32'(req_ready), 32'(1 << k));
      expect_wr(25'(10 * (k + 1)), IW'(k));
      tick();
    end
    req_valid = '0;
    check("rr_occ", 32'(occupancy), 4);

    // Fill to DEPTH with producer 0.
    req_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      set_data(0, 25'(100 + k));
      #1 check($sformatf("fill_ready_%0d", k), 32'(req_ready), 32'b0001);
      expect_wr(25'(100 + k), 2'd0);
      tick();
    end
    set_data(0, 25'd104);
    check("full_occ", 32'(occupancy), 8);
    #1 check("full_ready", 32'(req_ready), 0);
    tick();
    check("full_occ_hold", 32'(occupancy), 8);
    check("full_ready_hold", 32'(req_ready), 0);
    // One pop frees exactly one credit.
    fifo_rd_en = 1'b1;
    fifo_empty = 1'b0;
    tick();
    fifo_rd_en = 1'b0;
    fifo_empty = 1'b1;
    check("pop_occ", 32'(occupancy), 7);
    #1 check("pop_ready", 32'(req_ready), 32'b0001);
    expect_wr(25'd104, 2'd0);
    tick();
    req_valid = '0;
    check("refill_occ", 32'(occupancy), 8);
    check("refill_ovf", 32'(ovf_err), 0);

    // Drain to 5, then accept and pop together.
    fifo_rd_en = 1'b1;
    fifo_empty = 1'b0;
    repeat (3) tick();
    check("drain_occ", 32'(occupancy), 5);
    set_data(0, 25'd200);
    req_valid = 4'b0001;
    expect_wr(25'd200, 2'd0);
    tick();
    req_valid  = '0;
    fifo_rd_en = 1'b0;
    check("coincide_occ", 32'(occupancy), 5);
    // Read strobe on an empty FIFO is not a pop.
    fifo_rd_en = 1'b1;
    fifo_empty = 1'b1;
    tick();
    fifo_rd_en = 1'b0;
    check("empty_pop_occ", 32'(occupancy), 5);

    // Write issued while fifo_full is forced high.
    fifo_full = 1'b1;
    set_data(0, 25'd300);
    req_valid = 4'b0001;
    expect_wr(25'd300, 2'd0);
    tick();
    req_valid = '0;
    check("ovf_before", 32'(ovf_err), 0);
    tick();
    check("ovf_set", 32'(ovf_err), 1);
    fifo_full = 1'b0;
    tick();
    tick();
    check("ovf_sticky", 32'(ovf_err), 1);
    check("ovf_occ", 32'(occupancy), 6);
    rst = 1'b1;
    #1;
    check("ovf_cleared", 32'(ovf_err), 0);
    check("ovf_rst_occ", 32'(occupancy), 0);
    tick();
    rst = 1'b0;

    // Producers 0 and 2 both valid.
    set_data(0, 25'd500);
    set_data(2, 25'd502);
    req_valid = 4'b0101;
    for (int k = 0; k < 3; k++) begin
`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
      #1 check($sformatf("prio_ready_%0d", k), 32'(req_ready), 32'b0001);
      expect_wr(25'd500, 2'd0);
`else
      if (k == 1) begin
        #1 check($sformatf("prio_ready_%0d", k), 32'(req_ready), 32'b0100);
        expect_wr(25'd502, 2'd2);
      end else begin
        #1 check($sformatf("prio_ready_%0d", k), 32'(req_ready), 32'b0001);
        expect_wr(25'd500, 2'd0);
      end
`endif
      tick();
    end
    req_valid = '0;
    check("prio_occ", 32'(occupancy), 3);
    tick();
    tick();
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
